// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with registered reads and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr_a,
   input  logic [ADDR_W-1:0] i_rd_addr_b,
   output logic [DATA_W-1:0] o_rd_data_a,
   output logic [DATA_W-1:0] o_rd_data_b,
   output logic              o_rd_busy_a,
   output logic              o_rd_busy_b,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_sb_set_en,
   input  logic [ADDR_W-1:0] i_sb_set_addr,
   output logic [ADDR_W:0]   o_busy_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_count;
   logic [DATA_W-1:0] r_rd_data [2];
   logic              r_rd_busy [2];

   logic [DEPTH-1:0]  w_busy_nxt;
   logic [ADDR_W-1:0] w_rd_addr [2];
   logic [DATA_W-1:0] w_rd_data [2];
   logic              w_rd_busy [2];
   logic              w_wr_ok;
   logic              w_sb_ok;

   function automatic logic f_is_zero(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
   endfunction

   function automatic logic [ADDR_W:0] f_popcount(input logic [DEPTH-1:0] vec);
      logic [ADDR_W:0] cnt;
      cnt = {(ADDR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

   assign w_wr_ok      = i_wr_en     & ~f_is_zero(i_wr_addr);
   assign w_sb_ok      = i_sb_set_en & ~f_is_zero(i_sb_set_addr);
   assign w_rd_addr[0] = i_rd_addr_a;
   assign w_rd_addr[1] = i_rd_addr_b;

   // Next busy vector: a new producer (set) wins over a same-cycle writeback (clear).
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy_nxt[i] = (w_sb_ok && (i_sb_set_addr == ADDR_W'(i))) ? 1'b1 :
                         (w_wr_ok && (i_wr_addr == ADDR_W'(i)))     ? 1'b0 :
                                                                      r_busy[i];
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd_port
      // Read-port selection: array contents, optional forwarding, zero-register override.
      always_comb begin
`ifdef REGFILE_BYPASS_EN
         w_rd_data[p] = (w_wr_ok && (i_wr_addr == w_rd_addr[p])) ? i_wr_data
                                                                 : r_mem[w_rd_addr[p]];
         w_rd_busy[p] = w_busy_nxt[w_rd_addr[p]];
`else
         w_rd_data[p] = r_mem[w_rd_addr[p]];
         w_rd_busy[p] = r_busy[w_rd_addr[p]];
`endif
         if (f_is_zero(w_rd_addr[p])) begin
            w_rd_data[p] = {DATA_W{1'b0}};
            w_rd_busy[p] = 1'b0;
         end else begin
            w_rd_data[p] = w_rd_data[p];
            w_rd_busy[p] = w_rd_busy[p];
         end
      end

      // Registered read outputs, held while no read is requested.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_rd_data[p] <= {DATA_W{1'b0}};
            r_rd_busy[p] <= 1'b0;
         end else if (i_rd_en) begin
            r_rd_data[p] <= w_rd_data[p];
            r_rd_busy[p] <= w_rd_busy[p];
         end
      end
   end

   // Register array write port.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DATA_W{1'b0}};
         end
      end else if (w_wr_ok) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Scoreboard state and its population count, updated on the same edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy       <= {DEPTH{1'b0}};
         r_busy_count <= {(ADDR_W+1){1'b0}};
      end else begin
         r_busy       <= w_busy_nxt;
         r_busy_count <= f_popcount(w_busy_nxt);
      end
   end

   assign o_rd_data_a  = r_rd_data[0];
   assign o_rd_data_b  = r_rd_data[1];
   assign o_rd_busy_a  = r_rd_busy[0];
   assign o_rd_busy_b  = r_rd_busy[1];
   assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench for regfile_2r1w_sb: one instance with ZERO_REG=1, one with ZERO_REG=0,
// driven by shared directed stimulus; expectations are queued at issue and checked by a monitor.
module tb_regfile_2r1w_sb;

   typedef struct {
      logic [31:0] a, b;
      logic        ba, bb;
      logic [5:0]  cnt;
      logic [31:0] na, nb;
      logic        nba, nbb;
      logic [5:0]  ncnt;
   } exp_t;

   logic        clk, rst, rd_en, wr_en, sb_en;
   logic [4:0]  ra, rb, wa, sa;
   logic [31:0] wd;
   logic [31:0] z_da, z_db, n_da, n_db;
   logic        z_ba, z_bb, n_ba, n_bb;
   logic [5:0]  z_cnt, n_cnt;
   logic        v;
   exp_t        q[$];
   exp_t        nul;
   int          n_cmp, n_err;

   regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en),
      .i_rd_addr_a(ra), .i_rd_addr_b(rb),
      .o_rd_data_a(z_da), .o_rd_data_b(z_db), .o_rd_busy_a(z_ba), .o_rd_busy_b(z_bb),
      .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd),
      .i_sb_set_en(sb_en), .i_sb_set_addr(sa), .o_busy_count(z_cnt)
   );

   regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
      .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en),
      .i_rd_addr_a(ra), .i_rd_addr_b(rb),
      .o_rd_data_a(n_da), .o_rd_data_b(n_db), .o_rd_busy_a(n_ba), .o_rd_busy_b(n_bb),
      .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd),
      .i_sb_set_en(sb_en), .i_sb_set_addr(sa), .o_busy_count(n_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, b, input logic ba, bb, input logic [5:0] cnt,
                               input logic [31:0] na, nb, input logic nba, nbb,
                               input logic [5:0] ncnt);
      exp_t e;
      e.a = a; e.b = b; e.ba = ba; e.bb = bb; e.cnt = cnt;
      e.na = na; e.nb = nb; e.nba = nba; e.nbb = nbb; e.ncnt = ncnt;
      return e;
   endfunction

   // Read results are due on the edge after rd_en was sampled
   always @(posedge clk or posedge rst) begin
      if (rst) v <= 1'b0;
      else     v <= rd_en;
   end

   always @(negedge clk) begin
      exp_t e;
      if (v) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
         end else begin
            e = q.pop_front();
            chk("z_rd_data_a", z_da, e.a);
            chk("z_rd_data_b", z_db, e.b);
            chk("z_rd_busy_a", {31'd0, z_ba}, {31'd0, e.ba});
            chk("z_rd_busy_b", {31'd0, z_bb}, {31'd0, e.bb});
            chk("z_busy_count", {26'd0, z_cnt}, {26'd0, e.cnt});
            chk("n_rd_data_a", n_da, e.na);
            chk("n_rd_data_b", n_db, e.nb);
            chk("n_rd_busy_a", {31'd0, n_ba}, {31'd0, e.nba});
            chk("n_rd_busy_b", {31'd0, n_bb}, {31'd0, e.nbb});
            chk("n_busy_count", {26'd0, n_cnt}, {26'd0, e.ncnt});
         end
      end
   end

   task automatic idle();
      rd_en = 1'b0; wr_en = 1'b0; sb_en = 1'b0;
      ra = 5'd0; rb = 5'd0; wa = 5'd0; sa = 5'd0; wd = 32'd0;
   endtask

   task automatic step(input logic rd, input logic [4:0] a_addr, b_addr,
                       input logic we, input logic [4:0] w_addr, input logic [31:0] w_data,
                       input logic se, input logic [4:0] s_addr, input exp_t e);
      rd_en = rd; ra = a_addr; rb = b_addr;
      wr_en = we; wa = w_addr; wd = w_data;
      sb_en = se; sa = s_addr;
      if (rd) q.push_back(e);
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      nul = mk(32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_data_a", z_da, 32'd0);
      chk("reset_busy_a", {31'd0, z_ba}, 32'd0);
      chk("reset_count", {26'd0, z_cnt}, 32'd0);

      // 1: populate, then async reset mid-cycle with a pending write/set
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, nul);
      step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 6'd1, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 6'd1));
      @(negedge clk);
      #1;
      wr_en = 1'b1; wa = 5'd5; wd = 32'h00000001;
      sb_en = 1'b1; sa = 5'd8;
      #1 rst = 1'b1;
      #1;
      chk("async_rst_data_a", z_da, 32'd0);
      chk("async_rst_busy_b", {31'd0, z_bb}, 32'd0);
      chk("async_rst_count", {26'd0, z_cnt}, 32'd0);
      chk("async_rst_nz_data_a", n_da, 32'd0);
      @(posedge clk);
      #1;
      idle();
      rst = 1'b0;
      step(1'b1, 5'd5, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, nul);

      // 2: write then read, port B on r0
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, nul);
      step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'h12345678, 32'd0, 1'b0, 1'b0, 6'd0, 32'h12345678, 32'd0, 1'b0, 1'b0, 6'd0));

      // 3: write r0
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, nul);
      step(1'b1, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'd0, 32'h12345678, 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 6'd0));

      // 4: set busy, then writeback clears it
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, nul);
      step(1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'd0, 32'h12345678, 1'b1, 1'b0, 6'd1, 32'd0, 32'h12345678, 1'b1, 1'b0, 6'd1));
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h00000055, 1'b0, 5'd0, nul);
      step(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'h55, 32'h55, 1'b0, 1'b0, 6'd0, 32'h55, 32'h55, 1'b0, 1'b0, 6'd0));

      // 5: same-cycle set+write, then re-set of an already-busy register
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h000000AA, 1'b1, 5'd9, nul);
      step(1'b1, 5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'hAA, 32'h12345678, 1'b1, 1'b0, 6'd1, 32'hAA, 32'h12345678, 1'b1, 1'b0, 6'd1));
      step(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9,
           mk(32'hAA, 32'hAA, 1'b1, 1'b1, 6'd1, 32'hAA, 32'hAA, 1'b1, 1'b1, 6'd1));
      step(1'b1, 5'd3, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'h12345678, 32'hAA, 1'b0, 1'b1, 6'd1, 32'h12345678, 32'hAA, 1'b0, 1'b1, 6'd1));

      // 6: same-cycle write and read of r4
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h00000011, 1'b0, 5'd0, nul);
`ifdef REGFILE_BYPASS_EN
      step(1'b1, 5'd4, 5'd9, 1'b1, 5'd4, 32'h00000099, 1'b0, 5'd0,
           mk(32'h99, 32'hAA, 1'b0, 1'b1, 6'd1, 32'h99, 32'hAA, 1'b0, 1'b1, 6'd1));
`else
      step(1'b1, 5'd4, 5'd9, 1'b1, 5'd4, 32'h00000099, 1'b0, 5'd0,
           mk(32'h11, 32'hAA, 1'b0, 1'b1, 6'd1, 32'h11, 32'hAA, 1'b0, 1'b1, 6'd1));
`endif
      step(1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'h99, 32'h99, 1'b0, 1'b0, 6'd1, 32'h99, 32'h99, 1'b0, 1'b0, 6'd1));

      // Busy-set on r0 and top address r31
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd0, nul);
      step(1'b1, 5'd0, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
           mk(32'd0, 32'hCAFEF00D, 1'b0, 1'b0, 6'd1, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, 1'b0, 6'd2));

      // Outputs hold while rd_en is low even as addresses change
      step(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, nul);
      @(negedge clk);
      chk("hold_data_b", z_db, 32'hCAFEF00D);
      chk("hold_nz_data_a", n_da, 32'hFFFFFFFF);

      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised two-read/one-write register file for the MIPS datapath.
- Synchronous write and registered reads, with a per-register busy scoreboard for in-flight load/long-latency results.
- Sits between decode (reads, busy set) and writeback (write, busy clear).
- Address 0 is hardwired to zero when ZERO_REG=1.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never goes busy; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  capture read addresses this cycle.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  registered read data A.
- rd_data_b  out  DATA_W  registered read data B.
- rd_busy_a  out  1  registered busy flag of the register read on A.
- rd_busy_b  out  1  registered busy flag of the register read on B.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- sb_set_en  in  1  mark sb_set_addr busy (producer issued).
- sb_set_addr  in  ADDR_W  register to mark busy.
- busy_count  out  ADDR_W+1  number of busy registers.

Behaviour:
- Reset (async, immediate on rst high):
  - all registers 0, all busy bits 0.
  - rd_data_a/b = 0, rd_busy_a/b = 0, busy_count = 0.
- Reset mid-operation: any write or busy-set in that cycle is discarded.
- Write: on a rising edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. Only writes with wr_en=1 take effect; wr_addr=0 is not a disable.
- Read latency: 1 cycle.
  - rd_en=1 at edge N: rd_data_x and rd_busy_x are valid after edge N.
  - Outputs hold their value while rd_en=0.
- Same-cycle read/write, same address, without REGFILE_BYPASS_EN: the read returns the OLD value and the old busy flag.
- Scoreboard:
  - sb_set_en=1 at an edge sets busy[sb_set_addr].
  - sb_set_en and wr_en to the same address in the same cycle: data is written, busy ends SET (the new producer wins).
  - Set on an already-busy register: stays busy; busy_count is unchanged.
- busy_count:
  - registered popcount of the busy vector; updates on the same edge as the vector.
  - range 0..2**ADDR_W, no wrap.
- ZERO_REG=1:
  - writes to address 0 are dropped.
  - sb_set to address 0 is ignored.
  - reads of address 0 return 0, busy 0.
- Out-of-range addresses: not possible, since depth is exactly 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If rd_en, wr_en and rd_addr_x == wr_addr in the same cycle, rd_data_x captures wr_data and rd_busy_x captures 0.
  - If sb_set_en hits the same address in that cycle, rd_busy_x captures 1.
  - ZERO_REG still forces address 0 to 0.
- Undefined: no forwarding; reads return pre-edge contents as described in Behaviour.

Test Plan:
1. Assert rst mid-cycle after writing r5=0xDEADBEEF -> rd_data_a, rd_busy_a and busy_count go to 0 immediately, without waiting for a clock edge; a later read of r5 returns 0.
2. Write r3=0x12345678, next cycle read A=r3, B=r0 (ZERO_REG=1) -> one cycle later rd_data_a=0x12345678, rd_data_b=0.
3. Write r0=0xFFFFFFFF with ZERO_REG=1 -> later read of r0 returns 0. With ZERO_REG=0 -> returns 0xFFFFFFFF.
4. sb_set r7, read r7 -> rd_busy_a=1, busy_count=1. Then write r7=0x55 -> next read gives rd_busy_a=0, data 0x55, busy_count=0.
5. Same cycle: sb_set r9 and write r9=0xAA -> busy stays 1 and data 0xAA is stored. sb_set r9 again -> busy_count stays 1.
6. Same cycle: write r4=0x99 and read A=r4, with r4 previously 0x11 -> rd_data_a=0x11 without REGFILE_BYPASS_EN, 0x99 with it.
